// File: rtl/bp_nonsynth_commit_sampler.sv
// Commit-stream sampler: decimates committed PCs, stamps them with cycle and
// instruction index, and buffers the records in a first-word-fall-through FIFO.
module bp_nonsynth_commit_sampler #(
   parameter int vaddr_width_p   = 39,
   parameter int sample_period_p = 1,
   parameter int fifo_els_p      = 8,
   parameter int stamp_width_p   = 64,
   parameter int drop_width_p    = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     freeze_i,
   input  logic                     commit_v_i,
   input  logic [vaddr_width_p-1:0] commit_pc_i,
   output logic                     v_o,
   input  logic                     ready_i,
   output logic [vaddr_width_p-1:0] pc_o,
   output logic [stamp_width_p-1:0] cycle_o,
   output logic [stamp_width_p-1:0] instret_o,
   output logic [drop_width_p-1:0]  drop_cnt_o
);

   localparam int ptr_w_lp   = $clog2(fifo_els_p);
   localparam int phase_w_lp = (sample_period_p > 1) ? $clog2(sample_period_p) : 1;
   localparam logic [phase_w_lp-1:0] phase_last_lp = phase_w_lp'(sample_period_p - 1);
   localparam logic [ptr_w_lp:0]     full_cnt_lp   = (ptr_w_lp + 1)'(fifo_els_p);

   logic [stamp_width_p-1:0] cycle_r, instret_r;
   logic [phase_w_lp-1:0]    phase_r;
   logic [drop_width_p-1:0]  drop_r;
   logic [ptr_w_lp-1:0]      wptr_r, rptr_r;
   logic [ptr_w_lp:0]        count_r;

   logic [vaddr_width_p-1:0] pc_mem      [fifo_els_p];
   logic [stamp_width_p-1:0] cycle_mem   [fifo_els_p];
   logic [stamp_width_p-1:0] instret_mem [fifo_els_p];

   // Head fields seen by the consumer stay put once the FIFO runs dry.
   logic [vaddr_width_p-1:0] pc_hold_r;
   logic [stamp_width_p-1:0] cycle_hold_r, instret_hold_r;

   logic accept, sample, full, deq, enq, drop;

   assign accept = commit_v_i & ~freeze_i;
   assign sample = accept & (phase_r == phase_last_lp);
   assign full   = (count_r == full_cnt_lp);
   assign v_o    = (count_r != '0);
   assign deq    = v_o & ready_i;
   assign enq    = sample & (~full | deq);
   assign drop   = sample & ~enq;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cycle_r        <= '0;
         instret_r      <= '0;
         phase_r        <= '0;
         drop_r         <= '0;
         wptr_r         <= '0;
         rptr_r         <= '0;
         count_r        <= '0;
         pc_hold_r      <= '0;
         cycle_hold_r   <= '0;
         instret_hold_r <= '0;
      end else begin
         if (!freeze_i)
            cycle_r <= cycle_r + 1'b1;
         if (accept) begin
            instret_r <= instret_r + 1'b1;
            phase_r   <= (phase_r == phase_last_lp) ? '0 : phase_r + 1'b1;
         end
         if (drop && (drop_r != '1))
            drop_r <= drop_r + 1'b1;
         if (enq)
            wptr_r <= wptr_r + 1'b1;
         if (deq) begin
            rptr_r         <= rptr_r + 1'b1;
            pc_hold_r      <= pc_mem[rptr_r];
            cycle_hold_r   <= cycle_mem[rptr_r];
            instret_hold_r <= instret_mem[rptr_r];
         end
         if (enq && !deq)
            count_r <= count_r + 1'b1;
         else if (deq && !enq)
            count_r <= count_r - 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         pc_mem[wptr_r]      <= commit_pc_i;
         cycle_mem[wptr_r]   <= cycle_r;
         instret_mem[wptr_r] <= instret_r;
      end
   end

   assign pc_o       = v_o ? pc_mem[rptr_r]      : pc_hold_r;
   assign cycle_o    = v_o ? cycle_mem[rptr_r]   : cycle_hold_r;
   assign instret_o  = v_o ? instret_mem[rptr_r] : instret_hold_r;
   assign drop_cnt_o = drop_r;

endmodule
